// File: rtl/regfile_pkg.sv
// +--------------------------------------------------------------------+
// | regfile_pkg : shared constants and state type for the write arbiter |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int ZERO_REG  = 0;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin one-hot grant               |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   idx;

  // Walk from the farthest slot to the nearest so the nearest valid one wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign grant = en ? pick : '0;

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// +--------------------------------------------------------------------+
// | regfile_write_arbiter : round-robin share of the regfile write port |
// | with a clear sequencer; REGFILE_WB_BYPASS_EN enables read forwarding|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      we,
  output logic [ADDR_W-1:0]         writeSel,
  output logic [DATA_W-1:0]         data,
  input  logic [ADDR_W-1:0]         rd_sel_1,
  input  logic [ADDR_W-1:0]         rd_sel_2,
  input  logic [DATA_W-1:0]         rf_out_1,
  input  logic [DATA_W-1:0]         rf_out_2,
  output logic [DATA_W-1:0]         rd_out_1,
  output logic [DATA_W-1:0]         rd_out_2
);

  localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(REG_COUNT - 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wsel_q, wsel_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [NUM_REQ-1:0]  grant;
  logic                arb_en;
  logic                accept;
  logic [PTR_W-1:0]    gidx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // clear_start pre-empts any grant; reset also holds the grant low.
  assign arb_en = rst && (state_q == ARB) && !clear_start;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant)
  );

  assign accept = |grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  assign sel_addr = req_addr[gidx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[gidx*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wsel_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wsel_q  <= wsel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = FIRST_REG;
        end else if (accept) begin
          ptr_d = gidx;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_REG) state_d = ARB;
        else                   cnt_d   = cnt_q + ADDR_W'(1);
      end
      default: state_d = ARB;
    endcase
  end

  // Write port registers track cnt_d so the clear address appears with clear_busy.
  always_comb begin
    we_d   = 1'b0;
    wsel_d = wsel_q;
    data_d = data_q;
    if (state_d == CLEAR) begin
      we_d   = 1'b1;
      wsel_d = cnt_d;
      data_d = '0;
    end else if (state_q == ARB && accept) begin
      we_d   = (sel_addr != ZERO_ADDR);
      wsel_d = sel_addr;
      data_d = sel_data;
    end
  end

  assign req_ready  = grant;
  assign clear_busy = (state_q == CLEAR);
  assign we         = we_q;
  assign writeSel   = wsel_q;
  assign data       = data_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign rd_out_1 = (we_q && wsel_q == rd_sel_1 && rd_sel_1 != ZERO_ADDR) ? data_q : rf_out_1;
  assign rd_out_2 = (we_q && wsel_q == rd_sel_2 && rd_sel_2 != ZERO_ADDR) ? data_q : rf_out_2;
`else
  logic unused_rd_sel;
  assign unused_rd_sel = ^{rd_sel_1, rd_sel_2};
  assign rd_out_1      = rf_out_1;
  assign rd_out_2      = rf_out_2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_regfile_write_arbiter : directed + random bench with ref model  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_regfile_write_arbiter;
  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            rst   = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            clear_start, clear_busy, we;
  logic [AW-1:0]   writeSel, rd_sel_1, rd_sel_2;
  logic [DW-1:0]   data, rf_out_1, rf_out_2, rd_out_1, rd_out_2;

  int total = 0;
  int bad   = 0;

  // Reference model: pointer, committed write, clear counter (0 = arbitrating).
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_sel;
  logic [DW-1:0] m_data;
  int            m_clr;
  logic [N-1:0]  m_acc;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
    .clear_busy(clear_busy), .we(we), .writeSel(writeSel), .data(data),
    .rd_sel_1(rd_sel_1), .rd_sel_2(rd_sel_2), .rf_out_1(rf_out_1),
    .rf_out_2(rf_out_2), .rd_out_1(rd_out_1), .rd_out_2(rd_out_2)
  );

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] g = '0;
    if (!rst || m_clr != 0 || clear_start) return g;
    for (int k = 1; k <= N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] s, input logic [DW-1:0] rf);
    if (BYP && m_we && m_sel == s && s != 0) return m_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_we = 0; m_sel = '0; m_data = '0; m_clr = 0; m_acc = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] g;
    g = exp_ready();
    m_acc = '0;
    if (!rst) return;
    if (m_clr != 0) begin
      if (m_clr == 31) begin m_clr = 0; m_we = 0; end
      else begin m_clr++; m_we = 1; m_sel = AW'(m_clr); m_data = '0; end
    end else if (clear_start) begin
      m_clr = 1; m_we = 1; m_sel = AW'(1); m_data = '0;
    end else if (g != 0) begin
      m_acc = g;
      for (int i = 0; i < N; i++) if (g[i]) begin
        m_ptr  = i;
        m_sel  = req_addr[i*AW +: AW];
        m_data = req_data[i*DW +: DW];
        m_we   = (m_sel != 0);
      end
    end else begin
      m_we = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #2;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    total++; if (writeSel !== '0) begin bad++; $display("FAIL reset_wsel got=%0d exp=0", writeSel); end
    total++; if (data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", clear_busy); end
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL release_ready got=%b exp=01", req_ready); end
  endtask

  task automatic test_single_write();
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 32'hDEADBEEF;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", we); end
    total++; if (writeSel !== 5'd5) begin bad++; $display("FAIL single_wsel got=%0d exp=5", writeSel); end
    total++; if (data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", data); end
    cyc();
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL single_we_after got=%b exp=0", we); end
  endtask

  task automatic test_fairness();
    req_valid = 2'b11; req_addr = {5'd7, 5'd3}; req_data = {32'h7777_0001, 32'h3333_0000};
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (req_ready !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL fair_ready c=%0d got=%b", c, req_ready);
      end
      if (c > 0) begin
        total++;
        if (we !== 1'b1 || writeSel !== ((c % 2 == 1) ? 5'd7 : 5'd3)) begin
          bad++; $display("FAIL fair_wsel c=%0d got we=%b sel=%0d", c, we, writeSel);
        end
      end
      cyc();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_zero_reg();
    req_valid = 2'b10; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 32'h0000FFFF;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL zero_ready got=%b exp=10", req_ready); end
    cyc();
    req_valid = 2'b11; req_addr[0 +: AW] = 5'd12; req_data[0 +: DW] = 32'hABCD0012;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL zero_we got=%b exp=0", we); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL zero_next_ready got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    total++; if (we !== 1'b1 || writeSel !== 5'd12) begin bad++; $display("FAIL zero_next_write got we=%b sel=%0d exp 1/12", we, writeSel); end
  endtask

  task automatic test_clear();
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd4; req_data[0 +: DW] = 32'h0C0FFEE4;
    clear_start = 1'b1;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL clear_start_ready got=%b exp=00", req_ready); end
    cyc();
    clear_start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) clear_start = 1'b1;
      if (i == 11) clear_start = 1'b0;
      #1;
      total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL clear_busy i=%0d got=%b exp=1", i, clear_busy); end
      total++; if (we !== 1'b1) begin bad++; $display("FAIL clear_we i=%0d got=%b exp=1", i, we); end
      total++; if (writeSel !== AW'(i)) begin bad++; $display("FAIL clear_wsel got=%0d exp=%0d", writeSel, i); end
      total++; if (data !== '0) begin bad++; $display("FAIL clear_data i=%0d got=%h exp=0", i, data); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL clear_ready i=%0d got=%b exp=00", i, req_ready); end
      cyc();
    end
    #1;
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clear_done_busy got=%b exp=0", clear_busy); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL clear_done_ready got=%b exp=01", req_ready); end
    cyc();
    req_valid = 2'b00;
    #1;
    total++; if (we !== 1'b1 || writeSel !== 5'd4 || data !== 32'h0C0FFEE4) begin
      bad++; $display("FAIL clear_after_write got we=%b sel=%0d data=%h", we, writeSel, data);
    end
  endtask

  task automatic test_bypass();
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd9; req_data[0 +: DW] = 32'h00001234;
    rd_sel_1 = 5'd9; rf_out_1 = '0; rd_sel_2 = 5'd0; rf_out_2 = 32'hCAFE0002;
    cyc();
    req_valid = 2'b10; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 32'h5555AAAA;
    #1;
    total++; if (rd_out_1 !== (BYP ? 32'h00001234 : 32'h0)) begin bad++; $display("FAIL bypass_rd1 got=%h exp=%h", rd_out_1, BYP ? 32'h1234 : 32'h0); end
    total++; if (rd_out_2 !== 32'hCAFE0002) begin bad++; $display("FAIL bypass_rd2_sel0 got=%h exp=cafe0002", rd_out_2); end
    cyc();
    req_valid = 2'b00; rd_sel_2 = 5'd0; rf_out_2 = 32'hBEEF0003;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL bypass_zero_we got=%b exp=0", we); end
    total++; if (rd_out_2 !== 32'hBEEF0003) begin bad++; $display("FAIL bypass_rd2_zero got=%h exp=beef0003", rd_out_2); end
    total++; if (rd_out_1 !== 32'h0) begin bad++; $display("FAIL bypass_rd1_idle got=%h exp=0", rd_out_1); end
  endtask

  task automatic test_reset_mid_clear();
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    repeat (5) cyc();
    rst = 1'b0;
    #1;
    model_reset();
    total++; if (we !== 1'b0 || writeSel !== '0) begin bad++; $display("FAIL abort_write got we=%b sel=%0d exp 0/0", we, writeSel); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", clear_busy); end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL abort_ready got=%b exp=00", req_ready); end
    cyc();
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL abort_release_ready got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int t = 0; t < 400; t++) begin
      v = req_valid;
      for (int i = 0; i < N; i++) begin
        if (!v[i] || m_acc[i]) begin
          v[i] = ($urandom_range(0, 2) != 0);
          req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
          req_data[i*DW +: DW] = $urandom;
        end
      end
      req_valid   = v;
      clear_start = ($urandom_range(0, 39) == 0);
      rd_sel_1    = $urandom_range(0, 1) ? m_sel : AW'($urandom);
      rd_sel_2    = $urandom_range(0, 1) ? m_sel : AW'($urandom);
      rf_out_1    = $urandom;
      rf_out_2    = $urandom;
      #1;
      total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, req_ready, exp_ready()); end
      total++; if (we !== m_we) begin bad++; $display("FAIL rnd_we t=%0d got=%b exp=%b", t, we, m_we); end
      if (m_we) begin
        total++; if (writeSel !== m_sel || data !== m_data) begin
          bad++; $display("FAIL rnd_write t=%0d got=%0d/%h exp=%0d/%h", t, writeSel, data, m_sel, m_data);
        end
      end
      total++; if (clear_busy !== (m_clr != 0)) begin bad++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, clear_busy, m_clr != 0); end
      total++; if (rd_out_1 !== exp_rd(rd_sel_1, rf_out_1)) begin bad++; $display("FAIL rnd_rd1 t=%0d got=%h exp=%h", t, rd_out_1, exp_rd(rd_sel_1, rf_out_1)); end
      total++; if (rd_out_2 !== exp_rd(rd_sel_2, rf_out_2)) begin bad++; $display("FAIL rnd_rd2 t=%0d got=%h exp=%h", t, rd_out_2, exp_rd(rd_sel_2, rf_out_2)); end
      cyc();
    end
    req_valid   = '0;
    clear_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid   = 2'b11;
    req_addr    = {5'd2, 5'd1};
    req_data    = {32'h2222_2222, 32'h1111_1111};
    clear_start = 1'b0;
    rd_sel_1    = '0; rd_sel_2 = '0;
    rf_out_1    = '0; rf_out_2 = '0;
    model_reset();
    test_reset();
    test_single_write();
    test_fairness();
    test_zero_reg();
    test_clear();
    test_bypass();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between NUM_REQ writeback requesters, such as the ALU and the load unit.
- Uses a round-robin valid/ready handshake.
- Drives the register file's we/writeSel/data inputs from registered outputs.
- Contains a clear sequencer that zeroes registers 1..31 on command.
- Sits between the pipeline writeback stage and the register file.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant; request accepted when valid&ready at a clock edge
clear_start  in  1  single-cycle pulse that starts the clear sequence
clear_busy  out  1  high while the clear sequence runs
we  out  1  register file write enable (registered)
writeSel  out  ADDR_W  register file write address (registered)
data  out  DATA_W  register file write data (registered)
rd_sel_1, rd_sel_2  in  ADDR_W  read selects, shared with the register file
rf_out_1, rf_out_2  in  DATA_W  raw register file read data
rd_out_1, rd_out_2  out  DATA_W  read data delivered to the pipeline

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ARB; we=0, writeSel=0, data=0, clear_busy=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is forced to 0 while rst=0.
- States: ARB and CLEAR.
- ARB:
  - req_ready is combinational: one-hot, given to the first valid requester after the pointer, wrapping modulo NUM_REQ. It is 0 if no requester is valid, and never asserted to an invalid requester.
  - On acceptance at edge k: we/writeSel/data show the accepted request for the cycle after edge k, and the register file captures at edge k+1. Latency is 1 cycle and throughput is 1 write per cycle.
  - The pointer updates to the granted index on acceptance only.
  - If no acceptance at an edge, we=0 next cycle and writeSel/data hold their values.
  - A request to address 0 is accepted (ready=1) and advances the pointer, but we stays 0.
- ARB + clear_start=1:
  - clear_start wins; req_ready=0 that cycle.
  - Next state is CLEAR with counter=1.
- CLEAR:
  - Each cycle: we=1, writeSel=counter, data=0, clear_busy=1, req_ready=0.
  - Counter runs 1..31, for 31 write cycles; after writeSel=31 the state returns to ARB.
  - clear_busy drops in the first ARB cycle.
  - clear_start during CLEAR is ignored.
- Reset mid-CLEAR aborts immediately to the reset values. Partially cleared registers are not restored.
- Requesters must hold valid/addr/data stable until accepted; the block does not check this.

Optional Feature:
Macro: REGFILE_WB_BYPASS_EN
- Defined:
  - rd_out_n = data when we=1, writeSel=rd_sel_n and rd_sel_n!=0.
  - Otherwise rd_out_n = rf_out_n.
  - The mux is combinational and forwards the write being committed this cycle.
- Undefined: rd_out_n = rf_out_n. Ports remain present in both builds.

Decomposition:
- Package regfile_pkg:
  - REG_COUNT=32, ADDR_W=5, DATA_W=32, ZERO_REG=0.
  - State enum {ARB, CLEAR}.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. Reset behaviour: hold rst=0 with req_valid=2'b11 → we=0, writeSel=0, data=0, req_ready=0, clear_busy=0. Release rst → req_ready=2'b01 the same cycle.
2. Single write: req0 addr=5 data=32'hDEADBEEF accepted at edge k → cycle after k shows we=1, writeSel=5, data=DEADBEEF. The following cycle shows we=0.
3. Fairness: both requesters continuously valid (addr 3 / addr 7) → grants alternate 0,1,0,1; writeSel sequence is 3,7,3,7.
4. Zero register: req1 addr=0 data=32'hFFFF → req_ready[1]=1 and we stays 0. Next grant goes to req0.
5. Clear sequence: clear_start pulse together with req0 valid → req0 not accepted. clear_busy=1 for 31 cycles with writeSel 1..31, data=0, we=1, req_ready=0. Then req0 is accepted.
6. Bypass (macro defined): write addr 9 data 32'h1234 with rd_sel_1=9, rf_out_1=0 → rd_out_1=32'h1234 in the we cycle. With rd_sel_2=0 and an address-0 write, rd_out_2=rf_out_2. With the macro undefined, rd_out_1=0.
